// File: rtl/a2d_round_robin_seq_pkg.sv
// Shared types for the A2D round-robin sequencer: FSM states, channel index
// and the command-word encoding.
package a2d_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WAIT_C = 3'd2,
    GAP    = 3'd3,
    RD     = 3'd4,
    WAIT_R = 3'd5,
    STORE  = 3'd6
  } a2d_state_e;

  typedef enum logic [1:0] {
    LFT  = 2'd0,
    RGHT = 2'd1,
    BATT = 2'd2
  } a2d_ch_e;

  localparam logic [1:0] CMD_HDR = 2'b11;
  localparam logic [2:0] CH_LFT  = 3'd0;
  localparam logic [2:0] CH_RGHT = 3'd4;
  localparam logic [2:0] CH_BATT = 3'd5;

  function automatic logic [15:0] cmd_word(input a2d_ch_e idx);
    logic [2:0] ch;
    case (idx)
      LFT:     ch = CH_LFT;
      RGHT:    ch = CH_RGHT;
      default: ch = CH_BATT;
    endcase
    return {CMD_HDR, ch, 11'h000};
  endfunction

  function automatic a2d_ch_e next_ch(input a2d_ch_e idx);
    case (idx)
      LFT:     return RGHT;
      RGHT:    return BATT;
      default: return LFT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_round_robin_seq_if.sv
// Bus between the sequencer and the A2D SPI master.
interface a2d_round_robin_seq_if;
  // Handshake: spi_wrt is a one-cycle start pulse; spi_cmd stays stable from
  // that cycle until spi_done, a one-cycle completion pulse that also
  // qualifies spi_rd_data. At most one frame is outstanding at any time.
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;

  modport master (output spi_wrt, spi_cmd, input spi_done, spi_rd_data);
  modport slave  (input spi_wrt, spi_cmd, output spi_done, spi_rd_data);
endinterface

// File: rtl/a2d_round_robin_seq_timer.sv
// Loadable down-counter that stops at zero; shared by the conversion gap
// and the SPI transaction timeout.
module a2d_seq_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - ONE;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/a2d_round_robin_seq.sv
// Autonomous A2D scheduler: every ROUND_PERIOD cycles it converts the left
// load cell, right load cell and battery (command frame, gap, read frame).
module a2d_round_robin_seq
  import a2d_seq_pkg::*;
#(
  parameter logic [15:0] ROUND_PERIOD = 16'd50000,
  parameter logic [3:0]  GAP_CYC      = 4'd8,
  parameter logic [11:0] TIMEOUT_CYC  = 12'd2048
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  a2d_round_robin_seq_if.master         spi,
  output logic [11:0]                   lft_ld,
  output logic [11:0]                   rght_ld,
  output logic [11:0]                   batt,
  output logic                          rnd_vld,
  output logic                          a2d_err,
  output a2d_state_e                    state
);

  logic [15:0] per_cnt;
  logic        round_start;
  a2d_ch_e     idx;
  logic        rnd_bad;
  logic [11:0] rd_hold;
  logic        tmr_load;
  logic [11:0] tmr_val;
  logic        tmr_zero;
  logic        timeout;
  logic        advance;

  always_ff @(posedge clk) begin
    if (!rst_n || !en)                         per_cnt <= '0;
    else if (per_cnt == ROUND_PERIOD - 16'd1)  per_cnt <= '0;
    else                                       per_cnt <= per_cnt + 16'd1;
  end

  assign round_start = en && (per_cnt == 16'd0) && (state == IDLE);

  // Timer reaches zero in the (TIMEOUT_CYC-1)th cycle after spi_wrt, so the
  // error flag is visible exactly TIMEOUT_CYC cycles after the start pulse.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      CMD, RD: begin
        tmr_load = 1'b1;
        tmr_val  = TIMEOUT_CYC - 12'd2;
      end
      WAIT_C: if (spi.spi_done) begin
        tmr_load = 1'b1;
        tmr_val  = {8'h00, GAP_CYC - 4'd1};
      end
      default: ;
    endcase
  end

  a2d_seq_timer #(.W(12)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign timeout = ((state == WAIT_C) || (state == WAIT_R)) && !spi.spi_done && tmr_zero;
  assign advance = (state == STORE) || timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= LFT;
      spi.spi_wrt <= 1'b0;
      spi.spi_cmd <= 16'h0000;
      lft_ld      <= 12'h000;
      rght_ld     <= 12'h000;
      batt        <= 12'h000;
      rnd_vld     <= 1'b0;
      a2d_err     <= 1'b0;
      rnd_bad     <= 1'b0;
      rd_hold     <= 12'h000;
    end else begin
      spi.spi_wrt <= 1'b0;
      rnd_vld     <= 1'b0;
      case (state)
        IDLE: if (round_start) begin
          state       <= CMD;
          idx         <= LFT;
          rnd_bad     <= 1'b0;
          spi.spi_wrt <= 1'b1;
          spi.spi_cmd <= cmd_word(LFT);
        end
        CMD:    state <= WAIT_C;
        WAIT_C: if (spi.spi_done) state <= GAP;
        GAP: if (tmr_zero) begin
          state       <= RD;
          spi.spi_wrt <= 1'b1;
          spi.spi_cmd <= cmd_word(idx);
        end
        RD:     state <= WAIT_R;
        WAIT_R: if (spi.spi_done) begin
          rd_hold <= spi.spi_rd_data[11:0];
          state   <= STORE;
        end
        STORE: begin
          case (idx)
            LFT:     lft_ld  <= rd_hold;
            RGHT:    rght_ld <= rd_hold;
            default: batt    <= rd_hold;
          endcase
        end
        default: state <= IDLE;
      endcase

      if (timeout) begin
        a2d_err <= 1'b1;
        rnd_bad <= 1'b1;
      end

      // A timed-out transaction skips its channel but keeps the round moving.
      if (advance) begin
        if (idx == BATT) begin
          state   <= IDLE;
          idx     <= LFT;
          rnd_vld <= !(rnd_bad || timeout);
        end else begin
          state       <= CMD;
          idx         <= next_ch(idx);
          spi.spi_wrt <= 1'b1;
          spi.spi_cmd <= cmd_word(next_ch(idx));
        end
      end
    end
  end

endmodule

// File: tb/tb_a2d_round_robin_seq.sv
// Directed-random bench for a2d_round_robin_seq with a behavioural A2D/SPI model.
module tb_a2d_round_robin_seq;
  import a2d_seq_pkg::*;

  localparam int PERIOD = 200;
  localparam int TMO    = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        rnd_vld, a2d_err;
  a2d_state_e  state;

  a2d_round_robin_seq_if spi ();

  a2d_round_robin_seq #(
    .ROUND_PERIOD (16'd200),
    .GAP_CYC      (4'd8),
    .TIMEOUT_CYC  (12'd2048)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .spi     (spi),
    .lft_ld  (lft_ld),
    .rght_ld (rght_ld),
    .batt    (batt),
    .rnd_vld (rnd_vld),
    .a2d_err (a2d_err),
    .state   (state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A2D model state and observations
  int          lat = 40;
  int          frame_no = 0;
  int          drop_frame = -1;
  logic        stray_req = 1'b0;
  logic [11:0] val_tab [8];
  logic [2:0]  prev_ch = 3'd0;
  logic        busy = 1'b0;
  logic        hold = 1'b0;
  int          left = 0;
  logic [15:0] resp = 16'h0;

  logic [15:0] cmd_obs [$];
  int          wrt_cyc [$];
  int          vld_cyc [$];
  logic [11:0] batt_at_vld [$];
  int          vld_cnt = 0;
  int          overlap_cnt = 0;
  int          err_cyc = -1;

  logic [15:0] exp_q [$];
  logic [15:0] round_tab [6];

  int total = 0;
  int bad = 0;

  // The A2D answers every frame with the result of the previous command.
  initial begin
    for (int i = 0; i < 8; i++) val_tab[i] = 12'h000;
    spi.spi_done = 1'b0;
    spi.spi_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      spi.spi_done = 1'b0;
      if (rnd_vld) begin
        vld_cnt++;
        vld_cyc.push_back(cyc);
        batt_at_vld.push_back(batt);
      end
      if (a2d_err && err_cyc < 0) err_cyc = cyc;
      if (stray_req) begin
        stray_req = 1'b0;
        spi.spi_done = 1'b1;
        spi.spi_rd_data = 16'($urandom);
      end else if (spi.spi_wrt) begin
        if (busy) overlap_cnt++;
        cmd_obs.push_back(spi.spi_cmd);
        wrt_cyc.push_back(cyc);
        busy = 1'b1;
        left = lat;
        hold = (frame_no == drop_frame);
        frame_no++;
        resp = {4'($urandom), val_tab[prev_ch]};
        prev_ch = spi.spi_cmd[13:11];
      end else if (busy) begin
        left--;
        if (left == 0) begin
          busy = 1'b0;
          if (!hold) begin
            spi.spi_done = 1'b1;
            spi.spi_rd_data = resp;
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_vld(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (vld_cnt < n && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(vld_cnt >= n), 32'd1);
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000000;
  endfunction

  task automatic push_rounds(input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < 6; i++) exp_q.push_back(round_tab[i]);
  endtask

  task automatic check_cmds(input string tag);
    chk({tag, "_count"}, 32'(cmd_obs.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && cmd_obs.size() > 0)
      chk(tag, 32'(cmd_obs.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  task automatic clear_obs();
    cmd_obs.delete();
    wrt_cyc.delete();
    vld_cyc.delete();
    batt_at_vld.delete();
    vld_cnt = 0;
    overlap_cnt = 0;
  endtask

  task automatic rand_vals();
    val_tab[0] = 12'($urandom);
    val_tab[4] = 12'($urandom);
    val_tab[5] = 12'($urandom);
  endtask

  initial begin
    logic [11:0] old_r, s_l, s_r, s_b;
    int k;
    round_tab = '{16'hC000, 16'hC000, 16'hE000, 16'hE000, 16'hE800, 16'hE800};

    // reset
    rst_n = 1'b0;
    en = 1'b0;
    step(3);
    chk("rst_wrt", 32'(spi.spi_wrt), 32'd0);
    chk("rst_cmd", 32'(spi.spi_cmd), 32'h0000);
    chk("rst_lft", 32'(lft_ld), 32'h000);
    chk("rst_rght", 32'(rght_ld), 32'h000);
    chk("rst_batt", 32'(batt), 32'h000);
    chk("rst_vld", 32'(rnd_vld), 32'd0);
    chk("rst_err", 32'(a2d_err), 32'd0);
    chk("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    step(5);
    chk("idle_no_frames", 32'(cmd_obs.size()), 32'd0);

    // basic round, 40-cycle SPI latency
    lat = 40;
    val_tab[0] = 12'h123;
    val_tab[4] = 12'h456;
    val_tab[5] = 12'h789;
    clear_obs();
    en = 1'b1;
    wait_vld("basic_vld_wait", 1, 600);
    en = 1'b0;
    step(5);
    push_rounds(1);
    check_cmds("basic_cmd");
    chk("basic_lft", 32'(lft_ld), 32'h123);
    chk("basic_rght", 32'(rght_ld), 32'h456);
    chk("basic_batt", 32'(batt), 32'h789);
    chk("basic_vld_cnt", 32'(vld_cnt), 32'd1);
    chk("basic_batt_at_vld", 32'(batt_at_vld.size() > 0 ? batt_at_vld[0] : 12'hFFF), 32'h789);
    chk("basic_err", 32'(a2d_err), 32'd0);

    // periodicity: rounds fit within the period
    lat = 20;
    rand_vals();
    clear_obs();
    en = 1'b1;
    wait_vld("per_vld_wait", 3, 800);
    en = 1'b0;
    step(5);
    chk("per_lft_gap1", 32'(qget(wrt_cyc, 6) - qget(wrt_cyc, 0)), 32'(PERIOD));
    chk("per_lft_gap2", 32'(qget(wrt_cyc, 12) - qget(wrt_cyc, 6)), 32'(PERIOD));
    chk("per_vld_gap1", 32'(qget(vld_cyc, 1) - qget(vld_cyc, 0)), 32'(PERIOD));
    chk("per_vld_gap2", 32'(qget(vld_cyc, 2) - qget(vld_cyc, 1)), 32'(PERIOD));
    chk("per_vld_cnt", 32'(vld_cnt), 32'd3);
    push_rounds(3);
    check_cmds("per_cmd");
    chk("per_lft", 32'(lft_ld), 32'(val_tab[0]));
    chk("per_rght", 32'(rght_ld), 32'(val_tab[4]));
    chk("per_batt", 32'(batt), 32'(val_tab[5]));

    // overrun: a round longer than the period skips the next start
    lat = 40;
    rand_vals();
    clear_obs();
    en = 1'b1;
    wait_vld("ovr_vld_wait", 2, 1200);
    en = 1'b0;
    step(5);
    chk("ovr_start_gap", 32'(qget(wrt_cyc, 6) - qget(wrt_cyc, 0)), 32'(2 * PERIOD));
    chk("ovr_vld_gap", 32'(qget(vld_cyc, 1) - qget(vld_cyc, 0)), 32'(2 * PERIOD));
    chk("ovr_overlap", 32'(overlap_cnt), 32'd0);
    chk("ovr_vld_cnt", 32'(vld_cnt), 32'd2);
    push_rounds(2);
    check_cmds("ovr_cmd");

    // timeout on the right-channel read frame
    lat = 20;
    old_r = val_tab[4];
    rand_vals();
    if (val_tab[4] == old_r) val_tab[4] = ~old_r;
    clear_obs();
    err_cyc = -1;
    drop_frame = frame_no + 3;
    en = 1'b1;
    k = 0;
    while (err_cyc < 0 && k < 3000) begin
      step(1);
      k++;
    end
    chk("tmo_err_seen", 32'(err_cyc >= 0), 32'd1);
    chk("tmo_err_delay", 32'(err_cyc - qget(wrt_cyc, 3)), 32'(TMO));
    k = 0;
    while (wrt_cyc.size() < 6 && k < 300) begin
      step(1);
      k++;
    end
    chk("tmo_batt_frames", 32'(wrt_cyc.size() >= 6), 32'd1);
    step(40);
    chk("tmo_lft", 32'(lft_ld), 32'(val_tab[0]));
    chk("tmo_rght_kept", 32'(rght_ld), 32'(old_r));
    chk("tmo_batt", 32'(batt), 32'(val_tab[5]));
    chk("tmo_no_vld", 32'(vld_cnt), 32'd0);
    wait_vld("tmo_next_vld_wait", 1, 500);
    en = 1'b0;
    step(5);
    chk("tmo_next_vld_cnt", 32'(vld_cnt), 32'd1);
    chk("tmo_next_rght", 32'(rght_ld), 32'(val_tab[4]));
    chk("tmo_err_sticky", 32'(a2d_err), 32'd1);
    chk("tmo_overlap", 32'(overlap_cnt), 32'd0);
    drop_frame = -1;

    // enable drop during the right-channel gap, then a stray done
    lat = 20;
    rand_vals();
    clear_obs();
    en = 1'b1;
    k = 0;
    while (!(wrt_cyc.size() >= 3 && state == GAP) && k < 300) begin
      step(1);
      k++;
    end
    chk("en_gap_reached", 32'(state == GAP), 32'd1);
    en = 1'b0;
    wait_vld("en_vld_wait", 1, 300);
    step(300);
    chk("en_vld_cnt", 32'(vld_cnt), 32'd1);
    push_rounds(1);
    check_cmds("en_cmd");
    chk("en_lft", 32'(lft_ld), 32'(val_tab[0]));
    chk("en_rght", 32'(rght_ld), 32'(val_tab[4]));
    chk("en_batt", 32'(batt), 32'(val_tab[5]));
    s_l = lft_ld;
    s_r = rght_ld;
    s_b = batt;
    stray_req = 1'b1;
    step(6);
    chk("stray_lft", 32'(lft_ld), 32'(val_tab[0]));
    chk("stray_rght", 32'(rght_ld), 32'(val_tab[4]));
    chk("stray_batt", 32'(batt), 32'(val_tab[5]));
    chk("stray_vld", 32'(vld_cnt), 32'd1);
    chk("stray_err", 32'(a2d_err), 32'd1);
    chk("stray_state", 32'(state), 32'(IDLE));
    chk("stray_frames", 32'(wrt_cyc.size()), 32'd6);

    // reset in the middle of a read frame
    lat = 20;
    rand_vals();
    clear_obs();
    en = 1'b1;
    k = 0;
    while (state != WAIT_R && k < 200) begin
      step(1);
      k++;
    end
    chk("rst_mid_reached", 32'(state == WAIT_R), 32'd1);
    rst_n = 1'b0;
    en = 1'b0;
    step(1);
    chk("rstm_state", 32'(state), 32'(IDLE));
    chk("rstm_lft", 32'(lft_ld), 32'h000);
    chk("rstm_rght", 32'(rght_ld), 32'h000);
    chk("rstm_batt", 32'(batt), 32'h000);
    chk("rstm_wrt", 32'(spi.spi_wrt), 32'd0);
    chk("rstm_err", 32'(a2d_err), 32'd0);
    rst_n = 1'b1;
    step(40);
    chk("late_done_state", 32'(state), 32'(IDLE));
    chk("late_done_lft", 32'(lft_ld), 32'h000);
    chk("late_done_vld", 32'(vld_cnt), 32'd0);
    chk("late_done_frames", 32'(wrt_cyc.size()), 32'd2);
    chk("late_done_err", 32'(a2d_err), 32'd0);
    chk("late_done_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
